// File: rtl/dmi_req_queue.sv
// Core-side DMI request engine: buffers synchronized DMI requests, issues them
// to the debug register port with an ack timeout, and returns a status response.
module dmi_req_queue #(
    parameter int ABITS   = 7,
    parameter int DWIDTH  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              core_clk,
    input  logic              core_rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ABITS-1:0]  req_addr,
    input  logic [DWIDTH-1:0] req_data,
    input  logic              dmireset,
    output logic              reg_en,
    output logic              reg_wr_en,
    output logic [ABITS-1:0]  reg_wr_addr,
    output logic [DWIDTH-1:0] reg_wr_data,
    input  logic              reg_ack,
    input  logic [DWIDTH-1:0] rd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_data,
    output logic [1:0]        rsp_status,
    output logic [1:0]        sticky_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_FAIL = 2'b10;
    localparam logic [1:0] ST_BUSY = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    typedef struct packed {
        logic              wr;
        logic [ABITS-1:0]  addr;
        logic [DWIDTH-1:0] data;
    } entry_t;

    entry_t            fifo_q [DEPTH];
    logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    state_e            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              iss_wr_q, iss_wr_d;
    logic [1:0]        sticky_q, sticky_d;
    logic              reg_en_q, reg_en_d;
    logic              reg_wr_en_q, reg_wr_en_d;
    logic [ABITS-1:0]  reg_wr_addr_q, reg_wr_addr_d;
    logic [DWIDTH-1:0] reg_wr_data_q, reg_wr_data_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DWIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]        rsp_status_q, rsp_status_d;

    logic   full, empty, push, pop, overflow, timeout_hit;
    entry_t head;

    always_comb begin
        full        = (count_q == CW'(DEPTH));
        empty       = (count_q == '0);
        push        = req_valid && !full;
        overflow    = req_valid && full;
        pop         = (state_q == S_IDLE) && !empty;
        head        = fifo_q[rptr_q];
        timeout_hit = (state_q == S_WAIT) && !reg_ack && (timer_q == TW'(TIMEOUT - 1));
    end

    assign req_ready = !full;

    always_comb begin
        wptr_d  = wptr_q + PW'(push);
        rptr_d  = rptr_q + PW'(pop);
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // dmireset wins over any error raised in the same cycle
    always_comb begin
        sticky_d = sticky_q;
        if (dmireset) begin
            sticky_d = ST_OK;
        end else if (sticky_q == ST_OK) begin
            if (timeout_hit)   sticky_d = ST_FAIL;
            else if (overflow) sticky_d = ST_BUSY;
        end
    end

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        iss_wr_d      = iss_wr_q;
        reg_en_d      = 1'b0;
        reg_wr_en_d   = 1'b0;
        reg_wr_addr_d = reg_wr_addr_q;
        reg_wr_data_d = reg_wr_data_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_status_d  = rsp_status_q;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    state_d  = S_ISSUE;
                    iss_wr_d = head.wr;
                    // strobe is registered, so decide now using the sticky value ISSUE will see
                    if (sticky_d == ST_OK) begin
                        reg_en_d      = 1'b1;
                        reg_wr_en_d   = head.wr;
                        reg_wr_addr_d = head.addr;
                        reg_wr_data_d = head.data;
                    end
                end
            end
            S_ISSUE: begin
                if (sticky_q != ST_OK) begin
                    state_d      = S_RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = sticky_q;
                    rsp_data_d   = '0;
                end else begin
                    state_d = S_WAIT;
                    timer_d = '0;
                end
            end
            S_WAIT: begin
                if (reg_ack) begin
                    state_d      = S_RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = ST_OK;
                    rsp_data_d   = iss_wr_q ? '0 : rd_data;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d      = S_RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = ST_FAIL;
                    rsp_data_d   = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (push) fifo_q[wptr_q] <= '{wr: req_wr, addr: req_addr, data: req_data};
    end

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
            state_q       <= S_IDLE;
            timer_q       <= '0;
            iss_wr_q      <= 1'b0;
            sticky_q      <= ST_OK;
            reg_en_q      <= 1'b0;
            reg_wr_en_q   <= 1'b0;
            reg_wr_addr_q <= '0;
            reg_wr_data_q <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_status_q  <= ST_OK;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            timer_q       <= timer_d;
            iss_wr_q      <= iss_wr_d;
            sticky_q      <= sticky_d;
            reg_en_q      <= reg_en_d;
            reg_wr_en_q   <= reg_wr_en_d;
            reg_wr_addr_q <= reg_wr_addr_d;
            reg_wr_data_q <= reg_wr_data_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_status_q  <= rsp_status_d;
        end
    end

    assign reg_en      = reg_en_q;
    assign reg_wr_en   = reg_wr_en_q;
    assign reg_wr_addr = reg_wr_addr_q;
    assign reg_wr_data = reg_wr_data_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_status  = rsp_status_q;
    assign sticky_err  = sticky_q;
endmodule

// File: tb/tb_dmi_req_queue.sv
// Bench for dmi_req_queue: directed timing scenarios followed by a random
// transaction phase scored against a request/response queue model.
module tb_dmi_req_queue;
    localparam int ABITS   = 7;
    localparam int DWIDTH  = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    typedef struct {
        logic              wr;
        logic [ABITS-1:0]  addr;
        logic [DWIDTH-1:0] data;
    } req_t;

    typedef struct {
        logic [1:0]        st;
        logic [DWIDTH-1:0] data;
    } rsp_t;

    logic              core_clk = 1'b0;
    logic              core_rst_n;
    logic              req_valid, req_ready, req_wr;
    logic [ABITS-1:0]  req_addr;
    logic [DWIDTH-1:0] req_data;
    logic              dmireset;
    logic              reg_en, reg_wr_en;
    logic [ABITS-1:0]  reg_wr_addr;
    logic [DWIDTH-1:0] reg_wr_data;
    logic              reg_ack;
    logic [DWIDTH-1:0] rd_data;
    logic              rsp_valid, rsp_ready;
    logic [DWIDTH-1:0] rsp_data;
    logic [1:0]        rsp_status, sticky_err;

    int vectors = 0;
    int miscompares = 0;

    dmi_req_queue #(.ABITS(ABITS), .DWIDTH(DWIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .core_clk(core_clk), .core_rst_n(core_rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_data(req_data), .dmireset(dmireset),
        .reg_en(reg_en), .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr),
        .reg_wr_data(reg_wr_data), .reg_ack(reg_ack), .rd_data(rd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_status(rsp_status), .sticky_err(sticky_err)
    );

    always #5 core_clk = ~core_clk;

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_reg_en"}, 32'(reg_en), 0);
        chk({tag, "_reg_wr_en"}, 32'(reg_wr_en), 0);
        chk({tag, "_addr"}, 32'(reg_wr_addr), 0);
        chk({tag, "_wdata"}, reg_wr_data, 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_rsp_status"}, 32'(rsp_status), 0);
        chk({tag, "_sticky"}, 32'(sticky_err), 0);
        chk({tag, "_req_ready"}, 32'(req_ready), 1);
    endtask

    task automatic wait_issue(input string tag);
        int n = 0;
        while (!reg_en && n < 40) begin tick(); n++; end
        chk(tag, 32'(reg_en), 1);
    endtask

    task automatic push_req(input logic wr, input logic [ABITS-1:0] a, input logic [DWIDTH-1:0] d);
        req_valid = 1'b1; req_wr = wr; req_addr = a; req_data = d;
    endtask

    initial begin
        req_t q_iss[$];
        rsp_t q_rsp[$];
        req_t r;
        rsp_t e;
        int n, en_seen, pushed, consumed, ack_cd, d;
        logic ack_pend, seen;
        logic [DWIDTH-1:0] ack_dat;

        core_rst_n = 1'b0; req_valid = 0; req_wr = 0; req_addr = '0; req_data = '0;
        dmireset = 0; reg_ack = 0; rd_data = '0; rsp_ready = 0;
        tick(); tick();
        chk_idle("reset");
        core_rst_n = 1'b1;
        tick();

        // single read, ack one cycle after the strobe
        push_req(1'b0, 7'h10, 32'h0);
        tick();                                    // N+1
        req_valid = 0;
        chk("rd_en_n1", 32'(reg_en), 0);
        tick();                                    // N+2
        chk("rd_en_n2", 32'(reg_en), 1);
        chk("rd_wren", 32'(reg_wr_en), 0);
        chk("rd_addr", 32'(reg_wr_addr), 32'h10);
        tick();                                    // N+3
        chk("rd_en_n3", 32'(reg_en), 0);
        chk("rd_rsp_n3", 32'(rsp_valid), 0);
        reg_ack = 1; rd_data = 32'hDEADBEEF;
        tick();                                    // N+4
        reg_ack = 0; rd_data = 32'h0;
        chk("rd_rsp_n4", 32'(rsp_valid), 1);
        chk("rd_data", rsp_data, 32'hDEADBEEF);
        chk("rd_status", 32'(rsp_status), 0);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        chk("rd_rsp_done", 32'(rsp_valid), 0);

        // burst with the first write parked in RESP, fifth push overflows
        push_req(1'b1, 7'h20, 32'hA0);
        tick();
        req_valid = 0;
        wait_issue("bo_issue");
        chk("bo_wren", 32'(reg_wr_en), 1);
        chk("bo_wdata", reg_wr_data, 32'hA0);
        tick();
        reg_ack = 1;
        tick();
        reg_ack = 0;
        chk("bo_rsp", 32'(rsp_valid), 1);
        for (int k = 0; k < 5; k++) begin
            push_req(1'b1, 7'(7'h21 + k), 32'hB0 + 32'(k));
            chk($sformatf("bo_ready%0d", k), 32'(req_ready), 32'(k < 4));
            tick();
        end
        req_valid = 0;
        chk("bo_sticky", 32'(sticky_err), 32'h3);
        chk("bo_hold_valid", 32'(rsp_valid), 1);
        chk("bo_hold_status", 32'(rsp_status), 0);
        chk("bo_hold_data", rsp_data, 0);
        rsp_ready = 1;
        tick();
        n = 0; en_seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (reg_en) en_seen++;
            if (rsp_valid) begin
                chk("bo_busy_status", 32'(rsp_status), 32'h3);
                chk("bo_busy_data", rsp_data, 0);
                n++;
            end
            tick();
        end
        rsp_ready = 0;
        chk("bo_busy_count", 32'(n), 4);
        chk("bo_no_issue", 32'(en_seen), 0);
        chk("bo_ready_after", 32'(req_ready), 1);
        dmireset = 1;
        tick();
        dmireset = 0;
        chk("bo_cleared", 32'(sticky_err), 0);

        // timeout, then a late ack that must be ignored
        push_req(1'b0, 7'h30, 32'h0);
        tick();
        req_valid = 0;
        wait_issue("to_issue");
        n = 0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            tick();
            if (rsp_valid) n++;
        end
        chk("to_early", 32'(n), 0);
        tick();                                    // E+TIMEOUT+1
        chk("to_rsp", 32'(rsp_valid), 1);
        chk("to_status", 32'(rsp_status), 32'h2);
        chk("to_data", rsp_data, 0);
        chk("to_sticky", 32'(sticky_err), 32'h2);
        reg_ack = 1; rd_data = 32'h12345678;
        tick();
        reg_ack = 0;
        chk("to_late_status", 32'(rsp_status), 32'h2);
        chk("to_late_data", rsp_data, 0);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        chk("to_done", 32'(rsp_valid), 0);
        chk("to_sticky_kept", 32'(sticky_err), 32'h2);

        // fill under a sticky error, then dmireset against simultaneous overflows
        for (int k = 0; k < 5; k++) begin
            push_req(1'b0, 7'(7'h40 + k), 32'h0);
            tick();
        end
        chk("dr_full", 32'(req_ready), 0);
        dmireset = 1;
        tick();
        chk("dr_clear1", 32'(sticky_err), 0);
        tick();
        req_valid = 0; dmireset = 0;
        chk("dr_clear2", 32'(sticky_err), 0);
        chk("dr_first_status", 32'(rsp_status), 32'h2);
        rsp_ready = 1;
        tick();
        n = 0; en_seen = 0; ack_pend = 0;
        for (int c = 0; c < 60; c++) begin
            reg_ack = 0;
            if (ack_pend) begin reg_ack = 1; rd_data = 32'hC000 | 32'(reg_wr_addr); ack_pend = 0; end
            if (reg_en) begin en_seen++; ack_pend = 1; end
            if (rsp_valid) begin
                chk("dr_status", 32'(rsp_status), 0);
                chk("dr_data", rsp_data, 32'hC041 + 32'(n));
                n++;
            end
            tick();
        end
        reg_ack = 0; rsp_ready = 0;
        chk("dr_count", 32'(n), 4);
        chk("dr_issued", 32'(en_seen), 4);

        // ack on the last WAIT cycle wins over the timeout
        push_req(1'b0, 7'h50, 32'h0);
        tick();
        req_valid = 0;
        wait_issue("al_issue");
        repeat (TIMEOUT - 1) tick();
        chk("al_pending", 32'(rsp_valid), 0);
        tick();
        reg_ack = 1; rd_data = 32'hA5A55A5A;
        tick();
        reg_ack = 0;
        chk("al_rsp", 32'(rsp_valid), 1);
        chk("al_status", 32'(rsp_status), 0);
        chk("al_data", rsp_data, 32'hA5A55A5A);
        chk("al_sticky", 32'(sticky_err), 0);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;

        // reset while waiting with two entries queued
        for (int k = 0; k < 3; k++) begin
            push_req(1'b0, 7'(7'h60 + k), 32'h0);
            tick();
        end
        req_valid = 0;
        tick();
        #2 core_rst_n = 1'b0;
        #1 chk_idle("mrst");
        tick(); tick();
        core_rst_n = 1'b1;
        n = 0; en_seen = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (reg_en) en_seen++;
            if (rsp_valid) n++;
        end
        chk("mrst_no_rsp", 32'(n), 0);
        chk("mrst_no_issue", 32'(en_seen), 0);

        // random transactions against the queue model
        pushed = 0; consumed = 0; ack_cd = 0; seen = 0; ack_dat = '0;
        for (int cyc = 0; cyc < 1700; cyc++) begin
            req_valid = 0; dmireset = 0; rsp_ready = 0; reg_ack = 0;
            rd_data = $urandom;
            if (ack_cd > 0) begin
                ack_cd--;
                if (ack_cd == 0) begin reg_ack = 1; rd_data = ack_dat; end
            end
            if (reg_en) begin
                chk("rn_issue_pend", 32'(q_iss.size() > 0), 1);
                if (q_iss.size() > 0) begin
                    r = q_iss.pop_front();
                    chk("rn_addr", 32'(reg_wr_addr), 32'(r.addr));
                    chk("rn_wren", 32'(reg_wr_en), 32'(r.wr));
                    if (r.wr) chk("rn_wdata", reg_wr_data, r.data);
                    d = $urandom_range(1, TIMEOUT + 2);
                    ack_cd = d;
                    ack_dat = $urandom;
                    if (d <= TIMEOUT) begin e.st = 2'b00; e.data = r.wr ? '0 : ack_dat; end
                    else begin e.st = 2'b10; e.data = '0; end
                    q_rsp.push_back(e);
                end
            end
            if (rsp_valid) begin
                chk("rn_rsp_pend", 32'(q_rsp.size() > 0), 1);
                if (q_rsp.size() > 0) begin
                    e = q_rsp[0];
                    chk("rn_status", 32'(rsp_status), 32'(e.st));
                    chk("rn_data", rsp_data, e.data);
                    if (!seen) chk("rn_sticky", 32'(sticky_err), 32'(e.st));
                    seen = 1;
                    if (e.st != 2'b00) dmireset = 1;
                    rsp_ready = ($urandom_range(0, 2) != 0);
                    if (rsp_ready) begin void'(q_rsp.pop_front()); consumed++; seen = 0; end
                end
            end
            if (cyc < 1400 && (pushed - consumed) < DEPTH && $urandom_range(0, 2) == 0) begin
                r.wr = 1'($urandom); r.addr = 7'($urandom); r.data = $urandom;
                push_req(r.wr, r.addr, r.data);
                chk("rn_ready", 32'(req_ready), 1);
                q_iss.push_back(r);
                pushed++;
            end
            tick();
        end
        req_valid = 0; rsp_ready = 0; reg_ack = 0; dmireset = 0;
        chk("rn_drained", 32'(consumed), 32'(pushed));
        chk("rn_iss_left", 32'(q_iss.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
